// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl
// Purpose  : Sequences loader, PE-array and output-drain enables for one
//            5x5 ifmap / 3x3 filter convolution pass.
// Revision : 1.0
// ============================================================================
module conv_seq_ctrl #(
  parameter int IFMAP_BYTES    = 25,
  parameter int FILTER_BYTES   = 9,
  parameter int OUT_BYTES      = 9,
  parameter int COMPUTE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic reuse_filter,
  input  logic in_valid,
  output logic in_ready,
  input  logic out_ready,
  output logic out_valid,
  output logic out_last,
  output logic load_ifmap,
  output logic load_filter,
  output logic pe_en,
  output logic out_capture,
  output logic shift_out,
  output logic busy,
  output logic done,
  output logic filter_loaded
);

  localparam int c_max_io    = (FILTER_BYTES > OUT_BYTES) ? FILTER_BYTES : OUT_BYTES;
  localparam int c_max_bytes = (IFMAP_BYTES > c_max_io) ? IFMAP_BYTES : c_max_io;
  localparam int c_cnt_w     = (c_max_bytes > 1) ? $clog2(c_max_bytes) : 1;

  localparam logic [c_cnt_w-1:0] c_ifmap_last  = c_cnt_w'(IFMAP_BYTES - 1);
  localparam logic [c_cnt_w-1:0] c_filter_last = c_cnt_w'(FILTER_BYTES - 1);
  localparam logic [c_cnt_w-1:0] c_out_last    = c_cnt_w'(OUT_BYTES - 1);
  localparam logic [7:0]         c_cmp_last    = 8'(COMPUTE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_IFMAP  = 3'd1,
    S_LOAD_FILTER = 3'd2,
    S_COMPUTE     = 3'd3,
    S_CAPTURE     = 3'd4,
    S_DRAIN       = 3'd5,
    S_FINISH      = 3'd6
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]           r_cyc, w_cyc_nxt;
  logic                 r_skip_f, w_skip_f_nxt;
  logic                 r_filter_loaded, w_filter_loaded_nxt;

  // Decode is purely from registered state; handshake inputs only gate the strobes.
  assign in_ready      = (r_state == S_LOAD_IFMAP) || (r_state == S_LOAD_FILTER);
  assign load_ifmap    = (r_state == S_LOAD_IFMAP)  && in_valid;
  assign load_filter   = (r_state == S_LOAD_FILTER) && in_valid;
  assign pe_en         = (r_state == S_COMPUTE);
  assign out_capture   = (r_state == S_CAPTURE);
  assign out_valid     = (r_state == S_DRAIN);
  assign shift_out     = (r_state == S_DRAIN) && out_ready;
  assign out_last      = (r_state == S_DRAIN) && (r_cnt == c_out_last);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_FINISH);
  assign filter_loaded = r_filter_loaded;

  always_comb begin
    w_state_nxt         = r_state;
    w_cnt_nxt           = r_cnt;
    w_cyc_nxt           = r_cyc;
    w_skip_f_nxt        = r_skip_f;
    w_filter_loaded_nxt = r_filter_loaded;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_LOAD_IFMAP;
          w_skip_f_nxt = reuse_filter & r_filter_loaded;
          w_cnt_nxt    = '0;
          w_cyc_nxt    = '0;
        end
      end
      S_LOAD_IFMAP: begin
        if (load_ifmap) begin
          if (r_cnt == c_ifmap_last) begin
            w_state_nxt = r_skip_f ? S_COMPUTE : S_LOAD_FILTER;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_LOAD_FILTER: begin
        if (load_filter) begin
          if (r_cnt == c_filter_last) begin
            w_state_nxt         = S_COMPUTE;
            w_cnt_nxt           = '0;
            w_filter_loaded_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (r_cyc == c_cmp_last) begin
          w_state_nxt = S_CAPTURE;
          w_cyc_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + 8'd1;
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_DRAIN;
        w_cnt_nxt   = '0;
      end
      S_DRAIN: begin
        if (shift_out) begin
          if (r_cnt == c_out_last) begin
            w_state_nxt = S_FINISH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_cyc_nxt   = '0;
      end
    endcase
  end

  // Reset also drops filter residency, so an aborted pass leaves no stale filter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_cyc           <= '0;
      r_skip_f        <= 1'b0;
      r_filter_loaded <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_cyc           <= w_cyc_nxt;
      r_skip_f        <= w_skip_f_nxt;
      r_filter_loaded <= w_filter_loaded_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_seq_ctrl
// Purpose  : Directed self-checking bench for conv_seq_ctrl.
// Revision : 1.0
// ============================================================================
module tb_conv_seq_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic reuse_filter;
  logic in_valid;
  logic in_ready;
  logic out_ready;
  logic out_valid;
  logic out_last;
  logic load_ifmap;
  logic load_filter;
  logic pe_en;
  logic out_capture;
  logic shift_out;
  logic busy;
  logic done;
  logic filter_loaded;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int n_li = 0, n_lf = 0, n_pe = 0, n_cap = 0, n_sh = 0, n_last = 0;
  int n_done = 0, n_excl = 0;
  logic last_sh_last = 1'b0;

  conv_seq_ctrl #(
    .IFMAP_BYTES   (25),
    .FILTER_BYTES  (9),
    .OUT_BYTES     (9),
    .COMPUTE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .reuse_filter (reuse_filter),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .load_ifmap   (load_ifmap),
    .load_filter  (load_filter),
    .pe_en        (pe_en),
    .out_capture  (out_capture),
    .shift_out    (shift_out),
    .busy         (busy),
    .done         (done),
    .filter_loaded(filter_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (load_ifmap)  n_li  <= n_li + 1;
    if (load_filter) n_lf  <= n_lf + 1;
    if (pe_en)       n_pe  <= n_pe + 1;
    if (out_capture) n_cap <= n_cap + 1;
    if (shift_out) begin
      n_sh         <= n_sh + 1;
      last_sh_last <= out_last;
      if (out_last) n_last <= n_last + 1;
    end
    if (done) n_done <= n_done + 1;
    if ((int'(load_ifmap) + int'(load_filter) + int'(pe_en) +
         int'(out_capture) + int'(shift_out)) > 1)
      n_excl <= n_excl + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int outs_vec();
    return int'({in_ready, out_valid, out_last, load_ifmap, load_filter, pe_en,
                 out_capture, shift_out, busy, done, filter_loaded});
  endfunction

  task automatic run_pass(input string tag, input logic reuse, input bit stall,
                          input bit spur, input int exp_lat, input int exp_lf);
    int t0, rel, dcyc, hold;
    int s_li, s_lf, s_pe, s_cap, s_sh, s_last, s_done;
    bit got;
    s_li = n_li; s_lf = n_lf; s_pe = n_pe; s_cap = n_cap;
    s_sh = n_sh; s_last = n_last; s_done = n_done;
    got  = 1'b0;
    dcyc = -1;
    hold = stall ? 5 : 0;
    t0   = cyc;
    for (int k = 0; k < 400 && !got; k++) begin
      rel          = cyc - t0;
      start        = (rel == 0) || (spur && pe_en);
      reuse_filter = reuse;
      in_valid     = stall ? rel[0] : 1'b1;
      if (out_valid && hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else begin
        out_ready = 1'b1;
      end
      if (rel == 0) chk({tag, "_in_ready_at_start"}, int'(in_ready), 0);
      if (rel == 1) chk({tag, "_in_ready_after_start"}, int'(in_ready), 1);
      if (done) begin
        got  = 1'b1;
        dcyc = rel;
      end
      step();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_busy_after_done"}, int'(busy), 0);
    chk({tag, "_latency"}, dcyc + 1, exp_lat);
    chk({tag, "_load_ifmap"}, n_li - s_li, 25);
    chk({tag, "_load_filter"}, n_lf - s_lf, exp_lf);
    chk({tag, "_pe_en"}, n_pe - s_pe, 4);
    chk({tag, "_capture"}, n_cap - s_cap, 1);
    chk({tag, "_shift_out"}, n_sh - s_sh, 9);
    chk({tag, "_out_last_count"}, n_last - s_last, 1);
    chk({tag, "_out_last_on_final"}, int'(last_sh_last), 1);
    chk({tag, "_done_count"}, n_done - s_done, 1);
    chk({tag, "_filter_loaded"}, int'(filter_loaded), 1);
  endtask

  initial begin
    int d0;
    rst          = 1'b0;
    start        = 1'b0;
    reuse_filter = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    step(); step(); step();
    chk("reset_outputs", outs_vec(), 0);
    rst      = 1'b1;
    in_valid = 1'b0;
    step();

    // First pass asks for reuse with no resident filter: filter must still load.
    run_pass("p1_reuse_no_filter", 1'b1, 1'b0, 1'b0, 50, 9);
    run_pass("p2_reuse",           1'b1, 1'b0, 1'b0, 41, 0);

    // Start re-pulsed throughout COMPUTE must not trigger another pass.
    run_pass("p3_spur_start",      1'b0, 1'b0, 1'b1, 50, 9);
    d0 = n_done;
    step(); step(); step();
    chk("p3_idle_after_spur", int'(busy), 0);
    chk("p3_no_extra_done", n_done - d0, 0);

    // 24 + 9 input stall cycles plus 5 drain stalls on top of 50.
    run_pass("p4_stall",           1'b0, 1'b1, 1'b0, 88, 9);

    // Abort a pass mid filter load.
    d0           = n_done;
    start        = 1'b1;
    reuse_filter = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 27; i++) step();
    chk("abort_in_filter_load", int'(load_filter), 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_reset_outputs", outs_vec(), 0);
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_filter_cleared", int'(filter_loaded), 0);
    step();
    run_pass("p5_after_abort",     1'b1, 1'b0, 1'b0, 50, 9);

    chk("strobe_exclusive", n_excl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
